count_checker: RTL and testbench

Streaming checker for the free-running `counter` block's `count` output. It samples `count` every enabled clock and locks onto the increment-by-one sequence. Once locked, it flags every sample that breaks that sequence. It sits beside `counter` in the bench or in silicon as a self-check monitor, and its status outputs are read through the Ruby side.

---
 rtl/count_checker.sv | 135 +++++++++++++
 tb/tb_count_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// count_checker: lock-and-track monitor for the increment-by-one sequence
// produced by the free-running counter block. It acquires lock after a run
// of correct increments, then flags every sample that breaks the sequence.
// Optional feature macro: COUNT_CHECK_WRAP_EN adds the wrap_count port,
// which counts all-ones -> 0 rollovers seen while locked.

module count_checker #(
   parameter int unsigned Size      = 5,
   parameter int unsigned ErrWidth  = 8,
   parameter int unsigned LockLen   = 4,
   parameter int unsigned LossLen   = 2,
   parameter int unsigned WrapWidth = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [Size-1:0]     count,
   output logic [Size-1:0]     expected,
   output logic                locked,
   output logic                mismatch,
   output logic                error,
   output logic [ErrWidth-1:0] err_count
`ifdef COUNT_CHECK_WRAP_EN
   ,
   output logic [WrapWidth-1:0] wrap_count
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Run lengths are tracked in 4 bits, so both thresholds must fit 1..15.
   if (LockLen < 1 || LockLen > 15) begin : g_bad_lock_len
      $error("count_checker: LockLen must be in 1..15");
   end
   if (LossLen < 1 || LossLen > 15) begin : g_bad_loss_len
      $error("count_checker: LossLen must be in 1..15");
   end
   if (WrapWidth < 1) begin : g_bad_wrap_width
      $error("count_checker: WrapWidth must be at least 1");
   end

   state_t          state;
   logic [Size-1:0] last;
   logic [3:0]      match_run;
   logic [3:0]      miss_run;

   logic [Size-1:0] next_val;
   logic            hit;
   logic [3:0]      match_inc;
   logic [3:0]      miss_inc;
   logic            err_full;

   // Prediction and run-length increments for the current sample.
   always_comb begin
      next_val  = last + Size'(1);
      hit       = (count == next_val);
      match_inc = match_run + 4'd1;
      miss_inc  = miss_run + 4'd1;
      err_full  = &err_count;
   end

   // Acquire/track state machine with all status outputs registered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= '0;
         match_run <= '0;
         miss_run  <= '0;
         expected  <= '0;
         locked    <= 1'b0;
         mismatch  <= 1'b0;
         error     <= 1'b0;
         err_count <= '0;
`ifdef COUNT_CHECK_WRAP_EN
         wrap_count <= '0;
`endif
      end else begin
         mismatch <= 1'b0;
         if (enable) begin
            // Every enabled sample resyncs the prediction to the observed value.
            last     <= count;
            expected <= count + Size'(1);
            unique case (state)
               IDLE: begin
                  match_run <= '0;
                  state     <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (hit) begin
                     match_run <= match_inc;
                     if (match_inc == 4'(LockLen)) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_run <= '0;
                     end
                  end else begin
                     match_run <= '0;
                  end
               end
               LOCKED: begin
                  if (hit) begin
                     miss_run <= '0;
`ifdef COUNT_CHECK_WRAP_EN
                     if ((&last) && (count == '0)) begin
                        wrap_count <= wrap_count + WrapWidth'(1);
                     end
`endif
                  end else begin
                     mismatch <= 1'b1;
                     error    <= 1'b1;
                     if (!err_full) begin
                        err_count <= err_count + ErrWidth'(1);
                     end
                     miss_run <= miss_inc;
                     if (miss_inc == 4'(LossLen)) begin
                        state     <= ACQUIRE;
                        locked    <= 1'b0;
                        match_run <= '0;
                     end
                  end
               end
               default: begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: a driver issues directed and random
// samples and pushes the reference model's prediction; a monitor pops and
// compares after every clock edge.

module tb_count_checker;

   localparam int unsigned SZ      = 5;
   localparam int unsigned ERR_W   = 2;
   localparam int unsigned LOCK_N  = 4;
   localparam int unsigned LOSS_N  = 2;
   localparam int unsigned WRAP_W  = 16;
   localparam int          MOD     = 1 << SZ;
   localparam int          ERR_MAX = (1 << ERR_W) - 1;
   localparam int          WMOD    = 1 << WRAP_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [SZ-1:0]     count;
   logic [SZ-1:0]     expected;
   logic              locked;
   logic              mismatch;
   logic              error;
   logic [ERR_W-1:0]  err_count;
`ifdef COUNT_CHECK_WRAP_EN
   logic [WRAP_W-1:0] wrap_count;
`endif

   count_checker #(
      .Size(SZ), .ErrWidth(ERR_W), .LockLen(LOCK_N), .LossLen(LOSS_N), .WrapWidth(WRAP_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .count(count),
      .expected(expected), .locked(locked), .mismatch(mismatch),
      .error(error), .err_count(err_count)
`ifdef COUNT_CHECK_WRAP_EN
      , .wrap_count(wrap_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int exp_v;
      bit lock;
      bit mis;
      bit err;
      int ec;
      int wc;
   } resp_t;

   resp_t q[$];
   int tests = 0;
   int fails = 0;

   // Reference model: mode 0 = not yet sampled, 1 = hunting, 2 = tracking.
   int m_mode = 0, m_last = 0, m_good = 0, m_bad = 0, m_errs = 0, m_wraps = 0;
   bit m_err = 0, m_lock_out = 0;
   int m_exp_out = 0;

   function automatic resp_t model_step(bit rst, bit en, int cnt);
      resp_t r;
      bit mis = 0;
      if (!rst) begin
         m_mode = 0; m_last = 0; m_good = 0; m_bad = 0; m_errs = 0; m_wraps = 0;
         m_err = 0; m_lock_out = 0; m_exp_out = 0;
      end else if (en) begin
         bit ok = (cnt == (m_last + 1) % MOD);
         if (m_mode == 0) begin
            m_mode = 1; m_good = 0;
         end else if (m_mode == 1) begin
            m_good = ok ? m_good + 1 : 0;
            if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
         end else begin
            if (ok) begin
               m_bad = 0;
               if (m_last == MOD - 1 && cnt == 0) m_wraps = (m_wraps + 1) % WMOD;
            end else begin
               mis = 1; m_err = 1;
               m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
               m_bad++;
               if (m_bad == LOSS_N) begin m_mode = 1; m_good = 0; end
            end
         end
         m_last = cnt;
         m_lock_out = (m_mode == 2);
         m_exp_out = (cnt + 1) % MOD;
      end
      r.exp_v = m_exp_out; r.lock = m_lock_out; r.mis = mis;
      r.err = m_err; r.ec = m_errs; r.wc = m_wraps;
      return r;
   endfunction

   task automatic check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(bit rst, bit en, int cnt);
      @(negedge clock);
      reset  = rst;
      enable = en;
      count  = SZ'(cnt);
      q.push_back(model_step(rst, en, cnt));
   endtask

   // Direct check of an output against a constant, just after the edge.
   task automatic after_edge();
      @(posedge clock);
      #2;
   endtask

   task automatic relock(int start);
      for (int i = 0; i <= LOCK_N; i++) drive(1, 1, (start + i) % MOD);
   endtask

   // Monitor: compare DUT outputs against the scoreboard after each edge.
   initial begin
      resp_t r;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() != 0) begin
            r = q.pop_front();
            check("expected", int'(expected), r.exp_v);
            check("locked", int'(locked), int'(r.lock));
            check("mismatch", int'(mismatch), int'(r.mis));
            check("error", int'(error), int'(r.err));
            check("err_count", int'(err_count), r.ec);
`ifdef COUNT_CHECK_WRAP_EN
            check("wrap_count", int'(wrap_count), r.wc);
`endif
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int v;
      reset = 1'b0; enable = 1'b1; count = SZ'(7);
      drive(0, 1, 7);
      drive(0, 1, 7);
      after_edge();
      check("reset_locked", int'(locked), 0);
      check("reset_expected", int'(expected), 0);
      check("reset_err_count", int'(err_count), 0);

      for (int i = 0; i <= 4; i++) drive(1, 1, i);
      after_edge();
      check("acquire_locked", int'(locked), 1);
      check("acquire_expected", int'(expected), 5);

      for (int i = 5; i <= 31; i++) drive(1, 1, i);
      drive(1, 1, 0);
      drive(1, 1, 1);
      after_edge();
      check("wrap_expected", int'(expected), 2);
      check("wrap_no_error", int'(error), 0);

      for (int i = 2; i <= 10; i++) drive(1, 1, i);
      drive(1, 1, 15);
      after_edge();
      check("fault1_err_count", int'(err_count), 1);
      check("fault1_locked", int'(locked), 1);
      drive(1, 1, 16);
      drive(1, 1, 20);
      drive(1, 1, 25);
      after_edge();
      check("fault3_err_count", int'(err_count), 3);
      check("fault3_locked", int'(locked), 0);

      for (int k = 0; k < 3; k++) begin
         relock(26 + 7 * k);
         drive(1, 1, 3);
         drive(1, 1, 17);
      end
      after_edge();
      check("saturate_err_count", int'(err_count), ERR_MAX);
      check("saturate_error", int'(error), 1);

      relock(3);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, $urandom_range(MOD - 1));
         after_edge();
         check("gated_expected", int'(expected), 8);
         check("gated_mismatch", int'(mismatch), 0);
      end
      drive(1, 1, 8);
      after_edge();
      check("resume_mismatch", int'(mismatch), 0);
      check("resume_locked", int'(locked), 1);

      v = 0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(199) == 0) begin
            drive(0, $urandom_range(1), $urandom_range(MOD - 1));
         end else begin
            if ($urandom_range(7) == 0) v = $urandom_range(MOD - 1);
            else v = (v + 1) % MOD;
            drive(1, $urandom_range(7) != 0, v);
         end
      end

      drive(1, 0, 0);
      after_edge();
      after_edge();
      check("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
